// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the text-mode display path.
//   - screen geometry (80x30 tiles of 8x16 pixels)
//   - screen buffer word layout: 4 packed 7-bit character codes per 28-bit word
//   - per-pixel control flags that travel down the reader pipeline
package vga_pkg;

  localparam int H_TILES         = 80;
  localparam int V_TILES         = 30;
  localparam int CHAR_WIDTH      = 7;
  localparam int GLYPH_W         = 8;
  localparam int GLYPH_H         = 16;
  localparam int DATA_WIDTH      = 28;
  localparam int ADDR_WIDTH      = 10;
  localparam int FONT_ADDR_WIDTH = 11;
  localparam int RGB_WIDTH       = 12;
  localparam int COORD_WIDTH     = 10;
  localparam int LATENCY         = 5;

  // Flags that ride alongside each pixel; syncs idle high.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  // Bit offset of a character slot inside a screen word: slot*7 = slot*8 - slot.
  function automatic logic [4:0] slot_offset(input logic [1:0] slot);
    logic [4:0] s;
    s = {3'b000, slot};
    return (s << 3) - s;
  endfunction

endpackage

// File: rtl/vga_tile_reader_if.sv
// vga_tile_reader_if: timing-generator inputs, screen-buffer and font-ROM read
// ports and VGA pin outputs of the tile reader.
//   slave  : the tile reader itself
//   master : the surrounding environment (timing gen, memories, pins)
interface vga_tile_reader_if;
  import vga_pkg::*;

  logic [COORD_WIDTH-1:0]     x_i;
  logic [COORD_WIDTH-1:0]     y_i;
  logic                       active_i;
  logic                       hsync_i;
  logic                       vsync_i;
  logic [ADDR_WIDTH-1:0]      vr_addr_o;
  logic [DATA_WIDTH-1:0]      vr_data_i;
  logic [FONT_ADDR_WIDTH-1:0] font_addr_o;
  logic [GLYPH_W-1:0]         font_data_i;
  logic [RGB_WIDTH-1:0]       fg_i;
  logic [RGB_WIDTH-1:0]       bg_i;
  logic [RGB_WIDTH-1:0]       rgb_o;
  logic                       hsync_o;
  logic                       vsync_o;

  modport slave (
    input  x_i, y_i, active_i, hsync_i, vsync_i, vr_data_i, font_data_i, fg_i, bg_i,
    output vr_addr_o, font_addr_o, rgb_o, hsync_o, vsync_o
  );

  modport master (
    output x_i, y_i, active_i, hsync_i, vsync_i, vr_data_i, font_data_i, fg_i, bg_i,
    input  vr_addr_o, font_addr_o, rgb_o, hsync_o, vsync_o
  );

endinterface

// File: rtl/vga_tile_addr.sv
// vga_tile_addr: combinational tile index -> screen buffer word/slot.
//   col  in  7   tile column (x[9:3])
//   row  in  5   tile row (y[8:4])
//   word out 10  screen buffer word address (tile / 4)
//   slot out 2   character slot within the word (tile % 4)
module vga_tile_addr
  import vga_pkg::*;
(
  input  logic [6:0]            col,
  input  logic [4:0]            row,
  output logic [ADDR_WIDTH-1:0] word,
  output logic [1:0]            slot
);

  logic [11:0] tile;

  // row*80 as (row<<6)+(row<<4); max 29*80+79 = 2399 fits 12 bits.
  always_comb begin
    tile = ({7'b0, row} << 6) + ({7'b0, row} << 4) + {5'b0, col};
  end

  assign word = tile[11:2];
  assign slot = tile[1:0];

endmodule

// File: rtl/vga_tile_reader.sv
// vga_tile_reader: display-side reader of the 80x30 text buffer.
//   clk_i   in  pixel clock
//   rstn_i  in  async active-low reset
//   bus     slave modport of vga_tile_reader_if:
//     x_i/y_i/active_i/hsync_i/vsync_i  coordinates + syncs from timing gen
//     vr_addr_o -> vr_data_i            screen buffer read (data 1 cycle later)
//     font_addr_o -> font_data_i        font ROM read {char, glyph_row}
//     fg_i/bg_i                         colours, sampled at the output edge
//     rgb_o/hsync_o/vsync_o             VGA pins, 5 clocks after the inputs
// Every pixel carries its own slot/glyph-row/x-offset/flags down the pipe;
// there is no word caching, so adjacent pixels never share a fetch.
module vga_tile_reader
  import vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  vga_tile_reader_if.slave   bus
);

  localparam int STAGES = LATENCY - 1;

  logic [ADDR_WIDTH-1:0] word0;
  logic [1:0]            slot0;

  vga_tile_addr u_addr (
    .col  (bus.x_i[9:3]),
    .row  (bus.y_i[8:4]),
    .word (word0),
    .slot (slot0)
  );

  // y[9] only selects the vertical blanking region, which active_i already covers.
  logic unused_y9;
  assign unused_y9 = bus.y_i[9];

  ctl_t [STAGES:1]       ctl_pipe;
  logic [1:0]            slot1;
  logic [3:0]            gr1, gr2;
  logic [2:0]            px1, px2, px3;
  logic [CHAR_WIDTH-1:0] ch2;
  logic                  pix4;
  logic [4:0]            off1;

  assign off1 = slot_offset(slot1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctl_pipe        <= {STAGES{CTL_RST}};
      slot1           <= '0;
      gr1             <= '0;
      gr2             <= '0;
      px1             <= '0;
      px2             <= '0;
      px3             <= '0;
      ch2             <= '0;
      pix4            <= 1'b0;
      bus.vr_addr_o   <= '0;
      bus.font_addr_o <= '0;
      bus.rgb_o       <= '0;
      bus.hsync_o     <= 1'b1;
      bus.vsync_o     <= 1'b1;
    end else begin
      // stage 1: issue screen buffer read; address holds during blanking
      ctl_pipe[1] <= '{act: bus.active_i, hs: bus.hsync_i, vs: bus.vsync_i};
      for (int i = 2; i <= STAGES; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      if (bus.active_i) bus.vr_addr_o <= word0;
      slot1 <= slot0;
      gr1   <= bus.y_i[3:0];
      px1   <= bus.x_i[2:0];

      // stage 2: unpack character; blanked pixels never look at vr_data_i
      ch2 <= ctl_pipe[1].act ? bus.vr_data_i[off1 +: CHAR_WIDTH] : '0;
      gr2 <= gr1;
      px2 <= px1;

      // stage 3: font ROM address
      bus.font_addr_o <= {ch2, gr2};
      px3             <= px2;

      // stage 4: pick the glyph bit, bit 7 is the leftmost pixel
      pix4 <= ctl_pipe[3].act & bus.font_data_i[3'd7 - px3];

      // stage 5: colour + delay-matched syncs
      bus.rgb_o   <= ctl_pipe[STAGES].act ? (pix4 ? bus.fg_i : bus.bg_i) : '0;
      bus.hsync_o <= ctl_pipe[STAGES].hs;
      bus.vsync_o <= ctl_pipe[STAGES].vs;
    end
  end

endmodule

// File: tb/tb_vga_tile_reader.sv
// tb_vga_tile_reader: directed + randomized bench for vga_tile_reader with a
// behavioural model of the text display (tile = (y/16)*80 + x/8, etc.).
module tb_vga_tile_reader;
  import vga_pkg::*;

  localparam int HN = 1024;

  logic clk = 1'b0;
  logic rstn;
  always #20 clk = ~clk;

  vga_tile_reader_if bus();

  vga_tile_reader dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [27:0] scr [600];
  int          font_mode = 0;
  logic [7:0]  font_const = 8'h00;

  // history of applied inputs, indexed by capture cycle since reset
  int          hx [HN];
  int          hy [HN];
  bit          hact [HN];
  bit          hhs [HN];
  bit          hvs [HN];
  logic [11:0] hfg [HN];
  logic [11:0] hbg [HN];
  int          n;
  logic [9:0]  exp_vr;
  int          hs_low;

  function automatic logic [7:0] font_of(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd40503;
    case (font_mode)
      0:       return t[15:8] ^ t[7:0];
      1:       return {1'b0, a[10:4]};
      default: return font_const;
    endcase
  endfunction

  // environment memories: combinational read of the registered addresses
  always_comb begin
    bus.vr_data_i = (bus.vr_addr_o < 10'd600) ? scr[bus.vr_addr_o] : 28'h0;
  end
  always_comb begin
    bus.font_data_i = font_of(bus.font_addr_o);
  end

  function automatic logic [6:0] char_of(input int j);
    int tile, w, s;
    tile = (hy[j] / 16) * 80 + hx[j] / 8;
    w    = tile / 4;
    s    = tile % 4;
    return 7'((scr[w] >> (7 * s)) & 28'h7f);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int k);
    int j;
    logic [7:0] g;
    logic [11:0] e;
    chk("vr_addr", 32'(bus.vr_addr_o), 32'(exp_vr));
    if (k < 2) chk("font_addr_rst", 32'(bus.font_addr_o), 32'd0);
    else begin
      j = (k - 2) % HN;
      if (hact[j]) chk("font_addr", 32'(bus.font_addr_o), 32'({char_of(j), 4'(hy[j] % 16)}));
    end
    if (k < 4) begin
      chk("rgb_early", 32'(bus.rgb_o), 32'd0);
      chk("hsync_early", 32'(bus.hsync_o), 32'd1);
      chk("vsync_early", 32'(bus.vsync_o), 32'd1);
    end else begin
      j = (k - 4) % HN;
      e = 12'h000;
      if (hact[j]) begin
        g = font_of({char_of(j), 4'(hy[j] % 16)});
        e = g[7 - (hx[j] % 8)] ? hfg[k % HN] : hbg[k % HN];
      end
      chk("rgb", 32'(bus.rgb_o), 32'(e));
      chk("hsync", 32'(bus.hsync_o), 32'(hhs[j]));
      chk("vsync", 32'(bus.vsync_o), 32'(hvs[j]));
    end
    if (!bus.hsync_o) hs_low++;
  endtask

  // one pixel clock: drive, capture edge, check at the falling edge
  task automatic cyc(input int x, input int y, input bit act, input bit hs, input bit vs);
    int j;
    j = n % HN;
    bus.x_i = 10'(x); bus.y_i = 10'(y);
    bus.active_i = act; bus.hsync_i = hs; bus.vsync_i = vs;
    hx[j] = x; hy[j] = y; hact[j] = act; hhs[j] = hs; hvs[j] = vs;
    hfg[j] = bus.fg_i; hbg[j] = bus.bg_i;
    if (act) exp_vr = 10'(((y / 16) * 80 + x / 8) / 4);
    @(posedge clk);
    @(negedge clk);
    check_model(n);
    n++;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cyc(100, 500, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"}, 32'(bus.rgb_o), 32'd0);
    chk({tag, "_hs"}, 32'(bus.hsync_o), 32'd1);
    chk({tag, "_vs"}, 32'(bus.vsync_o), 32'd1);
    chk({tag, "_vr"}, 32'(bus.vr_addr_o), 32'd0);
    chk({tag, "_fa"}, 32'(bus.font_addr_o), 32'd0);
  endtask

  function automatic bit vis(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  function automatic bit hs_of(input int x);
    return !((x >= 656) && (x < 752));
  endfunction

  function automatic bit vs_of(input int y);
    return !((y >= 490) && (y < 492));
  endfunction

  task automatic line(input int y);
    for (int x = 0; x < 800; x++) cyc(x, y, vis(x, y), hs_of(x), vs_of(y));
  endtask

  logic [31:0] obs [16];

  initial begin
    rstn = 1'b0;
    n = 0; exp_vr = '0; hs_low = 0;
    bus.fg_i = 12'hFFF; bus.bg_i = 12'h000;
    for (int i = 0; i < 600; i++) scr[i] = 28'($urandom);

    // reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      bus.x_i = 10'($urandom_range(0, 799)); bus.y_i = 10'($urandom_range(0, 524));
      bus.active_i = 1'($urandom); bus.hsync_i = 1'($urandom); bus.vsync_i = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check_reset_vals("reset");
    rstn = 1'b1;

    // addressing corners
    cyc(8, 0, 1'b1, 1'b1, 1'b1);
    chk("addr_x8_y0", 32'(bus.vr_addr_o), 32'd0);
    cyc(0, 16, 1'b1, 1'b1, 1'b1);
    chk("addr_tile80", 32'(bus.vr_addr_o), 32'd20);
    cyc(639, 479, 1'b1, 1'b1, 1'b1);
    chk("addr_tile2399", 32'(bus.vr_addr_o), 32'd599);
    idle(6);

    // unpacking: chars 1,2,4,8 in slots 0..3, font returns the char code
    scr[0] = 28'h1010101;
    font_mode = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cyc(8 * i, 0, 1'b1, 1'b1, 1'b1);
      else cyc(100, 500, 1'b0, 1'b1, 1'b1);
      obs[i] = 32'(bus.font_addr_o);
    end
    chk("unpack_s0", obs[2], {21'd0, 7'd1, 4'd0});
    chk("unpack_s1", obs[3], {21'd0, 7'd2, 4'd0});
    chk("unpack_s2", obs[4], {21'd0, 7'd4, 4'd0});
    chk("unpack_s3", obs[5], {21'd0, 7'd8, 4'd0});
    idle(6);

    // serializer + latency with glyph row 8'h81
    font_mode = 2; font_const = 8'h81;
    bus.fg_i = 12'hFFF; bus.bg_i = 12'h000;
    for (int i = 0; i < 13; i++) begin
      if (i < 8) cyc(i, 0, 1'b1, 1'b1, 1'b1);
      else cyc(100, 500, 1'b0, 1'b1, 1'b1);
      obs[i] = 32'(bus.rgb_o);
    end
    chk("ser_before", obs[3], 32'h000);
    chk("ser_px0", obs[4], 32'hFFF);
    for (int i = 5; i < 11; i++) chk("ser_mid", obs[i], 32'h000);
    chk("ser_px7", obs[11], 32'hFFF);

    // blanking with an all-ones glyph
    font_const = 8'hFF;
    for (int i = 0; i < 6; i++) cyc(100, 100, 1'b0, 1'b1, 1'b1);
    chk("blank_rgb", 32'(bus.rgb_o), 32'h000);
    idle(2);

    // raster lines with real sync timing; random text, hashed font
    font_mode = 0;
    for (int i = 0; i < 600; i++) scr[i] = 28'($urandom);
    bus.fg_i = 12'h0F0; bus.bg_i = 12'h00F;
    hs_low = 0;
    line(0);
    idle(6);
    chk("hs_width", 32'(hs_low), 32'd96);
    line(15);
    line(16);
    line(479);
    chk("addr_last", 32'(bus.vr_addr_o), 32'd599);
    line(480);
    chk("vr_hold_480", 32'(bus.vr_addr_o), 32'd599);
    line(490);

    // mid-frame reset at x=300
    for (int x = 0; x <= 300; x++) cyc(x, 100, 1'b1, hs_of(x), 1'b1);
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n = 0; exp_vr = '0;
    for (int x = 301; x < 800; x++) cyc(x, 100, vis(x, 100), hs_of(x), 1'b1);

    // random coordinates, colours and syncs
    for (int i = 0; i < 800; i++) begin
      int x, y;
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      bus.fg_i = 12'($urandom); bus.bg_i = 12'($urandom);
      cyc(x, y, vis(x, y), 1'($urandom), 1'($urandom));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
